// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Brief    : Shared processor definitions: fetch FSM encoding, bubble
//            instruction, default reset PC and address helpers.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

   localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr & 32'h0000_0003) != 32'h0000_0000;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with flush, hold and load controls.
//            Flush wins over hold, hold wins over load.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = C_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic        i_flush,
   input  logic        i_hold,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr
);

   logic        r_valid;
   logic [31:0] r_pc;
   logic [31:0] r_instr;

   // A flush keeps the old PC; only validity and the instruction word change.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_pc    <= 32'h0000_0000;
         r_instr <= NOP_INSTR;
      end else if (i_flush) begin
         r_valid <= 1'b0;
         r_instr <= NOP_INSTR;
      end else if (i_load && !i_hold) begin
         r_valid <= 1'b1;
         r_pc    <= i_pc;
         r_instr <= i_instr;
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_instr = r_instr;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch stage: PC register, BOOT/RUN/HALTED control
//            FSM, redirect handling, sticky fault flag and IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = C_RESET_PC,
   parameter int unsigned IMEM_BYTES = 32,
   parameter logic [31:0] NOP_INSTR  = C_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_req,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        fetch_fault,
   output logic        halted
);

   localparam logic [31:0] C_LAST_PC = 32'(IMEM_BYTES - 32'd4);

   fetch_state_t r_state;
   fetch_state_t w_state_next;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_next;
   logic         r_fault;
   logic         w_fault_next;
   logic         w_load;
   logic         w_flush;
   logic         w_hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_BOOT;
         r_pc    <= RESET_PC;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_fault <= w_fault_next;
      end
   end

   // Redirect is checked ahead of the state decode so it overrides stall,
   // halt_req and the HALTED state alike.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_fault_next = r_fault;
      w_load       = 1'b0;
      w_flush      = 1'b0;

      if (redirect_valid) begin
         w_pc_next    = word_align(redirect_pc);
         w_flush      = 1'b1;
         w_state_next = ST_RUN;
         if (is_misaligned(redirect_pc)) begin
            w_fault_next = 1'b1;
         end
      end else begin
         case (r_state)
            ST_BOOT: begin
               w_state_next = ST_RUN;
            end
            ST_RUN: begin
               if (stall) begin
                  w_state_next = ST_RUN;
               end else if (r_pc > C_LAST_PC) begin
                  w_flush      = 1'b1;
                  w_fault_next = 1'b1;
                  w_state_next = ST_HALTED;
               end else if (halt_req) begin
                  w_flush      = 1'b1;
                  w_state_next = ST_HALTED;
               end else begin
                  w_load    = 1'b1;
                  w_pc_next = r_pc + 32'd4;
               end
            end
            ST_HALTED: begin
               w_state_next = ST_HALTED;
            end
            default: begin
               w_state_next = ST_BOOT;
            end
         endcase
      end
   end

   assign w_hold = !(w_load || w_flush);

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_flush (w_flush),
      .i_hold  (w_hold),
      .i_pc    (r_pc),
      .i_instr (imem_instr),
      .o_valid (id_valid),
      .o_pc    (id_pc),
      .o_instr (id_instr)
   );

   assign imem_pc     = r_pc;
   assign fetch_fault = r_fault;
   assign halted      = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        halt_req = 1'b0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        fetch_fault;
   logic        halted;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [8];

   // Model state: PC, boot/halt flags and the expected IF/ID contents.
   logic [31:0] m_pc;
   bit          m_boot;
   bit          m_halt;
   bit          e_valid;
   logic [31:0] e_pc;
   logic [31:0] e_instr;
   bit          e_instr_x;
   bit          e_fault;

   always #5 clk = ~clk;

   always_comb imem_instr = (imem_pc < 32'd32) ? mem[imem_pc[4:2]] : 32'hDEAD_BEEF;

   fetch_stage #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_BYTES (32),
      .NOP_INSTR  (NOP)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_pc        (imem_pc),
      .imem_instr     (imem_instr),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_instr       (id_instr),
      .fetch_fault    (fetch_fault),
      .halted         (halted)
   );

   task automatic fill_mem();
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_boot = 1; m_halt = 0;
      e_valid = 0; e_pc = 32'h0; e_instr = NOP; e_instr_x = 0; e_fault = 0;
   endtask

   task automatic model_step();
      if (redirect_valid) begin
         m_pc = redirect_pc & ~32'h3;
         e_valid = 0; e_instr = NOP; e_instr_x = 0;
         if (redirect_pc % 4 != 0) e_fault = 1;
         m_boot = 0; m_halt = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (m_halt || stall) begin
         // nothing moves
      end else if (m_pc > 32'd28) begin
         e_valid = 0; e_instr = NOP; e_instr_x = 0; e_fault = 1; m_halt = 1;
      end else if (halt_req) begin
         e_valid = 0; e_instr_x = 1; m_halt = 1;
      end else begin
         e_valid = 1; e_pc = m_pc; e_instr = mem[m_pc / 4]; e_instr_x = 0;
         m_pc = m_pc + 4;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      model_reset();
      #1;
      n_checks++; if (imem_pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc got=%h exp=%h", imem_pc, 32'h0); end
      n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
      n_checks++; if (id_pc !== 32'h0) begin n_errors++; $display("FAIL reset_id_pc got=%h exp=0", id_pc); end
      n_checks++; if (id_instr !== NOP) begin n_errors++; $display("FAIL reset_instr got=%h exp=%h", id_instr, NOP); end
      n_checks++; if (fetch_fault !== 1'b0 || halted !== 1'b0) begin n_errors++; $display("FAIL reset_flags got=%b%b exp=00", fetch_fault, halted); end
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_boot();
      mem[0] = 32'hFFC4_A303;
      cycle();
      n_checks++; if (id_valid !== 1'b0 || imem_pc !== 32'h0) begin n_errors++; $display("FAIL boot_cycle got valid=%b pc=%h exp valid=0 pc=0", id_valid, imem_pc); end
      cycle();
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'hFFC4_A303) begin n_errors++; $display("FAIL first_fetch got %b/%h/%h exp 1/0/ffc4a303", id_valid, id_pc, id_instr); end
      n_checks++; if (imem_pc !== 32'h4) begin n_errors++; $display("FAIL first_fetch_pc got=%h exp=4", imem_pc); end
   endtask

   task automatic test_stall();
      logic [31:0] s_pc, s_instr;
      logic        s_valid;
      cycle();
      s_valid = id_valid; s_pc = id_pc; s_instr = id_instr;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++; if (imem_pc !== 32'h8 || id_valid !== s_valid || id_pc !== s_pc || id_instr !== s_instr) begin
            n_errors++; $display("FAIL stall_hold[%0d] got pc=%h id=%b/%h/%h exp pc=8 id=%b/%h/%h", i, imem_pc, id_valid, id_pc, id_instr, s_valid, s_pc, s_instr);
         end
      end
      stall = 1'b0;
      cycle();
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== mem[2] || imem_pc !== 32'hC) begin
         n_errors++; $display("FAIL stall_release got %b/%h/%h pc=%h exp 1/8/%h pc=c", id_valid, id_pc, id_instr, imem_pc, mem[2]);
      end
   endtask

   task automatic test_redirect_stall();
      redirect_valid = 1'b1; redirect_pc = 32'h10; stall = 1'b1;
      cycle();
      redirect_valid = 1'b0; stall = 1'b0;
      n_checks++; if (imem_pc !== 32'h10 || id_valid !== 1'b0 || id_instr !== NOP || fetch_fault !== 1'b0) begin
         n_errors++; $display("FAIL redirect_stall got pc=%h v=%b i=%h f=%b exp pc=10 v=0 i=13 f=0", imem_pc, id_valid, id_instr, fetch_fault);
      end
   endtask

   task automatic test_misaligned();
      redirect_valid = 1'b1; redirect_pc = 32'h0E;
      cycle();
      redirect_valid = 1'b0;
      n_checks++; if (imem_pc !== 32'hC || fetch_fault !== 1'b1) begin n_errors++; $display("FAIL misaligned got pc=%h f=%b exp pc=c f=1", imem_pc, fetch_fault); end
      for (int i = 0; i < 3; i++) cycle();
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      cycle();
      redirect_valid = 1'b0;
      n_checks++; if (fetch_fault !== 1'b1 || imem_pc !== 32'h0) begin n_errors++; $display("FAIL fault_sticky got f=%b pc=%h exp f=1 pc=0", fetch_fault, imem_pc); end
   endtask

   task automatic test_out_of_range();
      fill_mem();
      do_reset();
      cycle();
      for (int i = 0; i < 8; i++) begin
         cycle();
         n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_instr !== mem[i]) begin
            n_errors++; $display("FAIL seq_fetch[%0d] got %b/%h/%h exp 1/%h/%h", i, id_valid, id_pc, id_instr, 32'(4 * i), mem[i]);
         end
      end
      n_checks++; if (imem_pc !== 32'h20 || halted !== 1'b0 || fetch_fault !== 1'b0) begin n_errors++; $display("FAIL at_limit got pc=%h h=%b f=%b exp pc=20 h=0 f=0", imem_pc, halted, fetch_fault); end
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++; if (fetch_fault !== 1'b1 || halted !== 1'b1 || id_valid !== 1'b0 || id_instr !== NOP || imem_pc !== 32'h20) begin
            n_errors++; $display("FAIL out_of_range[%0d] got f=%b h=%b v=%b i=%h pc=%h exp 1 1 0 13 20", i, fetch_fault, halted, id_valid, id_instr, imem_pc);
         end
      end
   endtask

   task automatic test_halt_vs_redirect();
      do_reset();
      cycle();
      cycle();
      halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4;
      cycle();
      redirect_valid = 1'b0;
      n_checks++; if (halted !== 1'b0 || imem_pc !== 32'h4) begin n_errors++; $display("FAIL halt_redirect got h=%b pc=%h exp h=0 pc=4", halted, imem_pc); end
      stall = 1'b1;
      cycle();
      n_checks++; if (halted !== 1'b0 || imem_pc !== 32'h4) begin n_errors++; $display("FAIL halt_under_stall got h=%b pc=%h exp h=0 pc=4", halted, imem_pc); end
      stall = 1'b0;
      cycle();
      halt_req = 1'b0;
      n_checks++; if (halted !== 1'b1 || id_valid !== 1'b0 || imem_pc !== 32'h4) begin n_errors++; $display("FAIL halt got h=%b v=%b pc=%h exp 1 0 4", halted, id_valid, imem_pc); end
      cycle(); cycle();
      n_checks++; if (halted !== 1'b1 || imem_pc !== 32'h4 || id_valid !== 1'b0) begin n_errors++; $display("FAIL halt_frozen got h=%b pc=%h v=%b exp 1 4 0", halted, imem_pc, id_valid); end
      redirect_valid = 1'b1; redirect_pc = 32'h8;
      cycle();
      redirect_valid = 1'b0;
      cycle();
      n_checks++; if (halted !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== mem[2]) begin
         n_errors++; $display("FAIL halt_exit got h=%b %b/%h/%h exp 0 1/8/%h", halted, id_valid, id_pc, id_instr, mem[2]);
      end
   endtask

   task automatic test_reset_midflight();
      cycle(); cycle();
      @(posedge clk);
      #3 reset = 1'b0;
      model_reset();
      #1;
      n_checks++; if (imem_pc !== 32'h0 || id_valid !== 1'b0 || id_instr !== NOP || halted !== 1'b0 || fetch_fault !== 1'b0) begin
         n_errors++; $display("FAIL midflight_reset got pc=%h v=%b i=%h h=%b f=%b exp 0 0 13 0 0", imem_pc, id_valid, id_instr, halted, fetch_fault);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      cycle();
      cycle();
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== mem[0]) begin n_errors++; $display("FAIL midflight_refetch got %b/%h/%h exp 1/0/%h", id_valid, id_pc, id_instr, mem[0]); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if (c % 100 == 0) begin
            fill_mem();
            do_reset();
         end
         stall          = ($urandom_range(0, 99) < 25);
         halt_req       = ($urandom_range(0, 99) < 4);
         redirect_valid = ($urandom_range(0, 99) < 10);
         redirect_pc    = 32'($urandom_range(0, 10) * 4);
         if ($urandom_range(0, 99) < 5) redirect_pc = redirect_pc + 32'($urandom_range(1, 3));
         cycle();
         n_checks++; if (imem_pc !== m_pc || halted !== m_halt || fetch_fault !== e_fault || id_valid !== e_valid) begin
            n_errors++; $display("FAIL rand[%0d] ctrl got pc=%h h=%b f=%b v=%b exp pc=%h h=%b f=%b v=%b", c, imem_pc, halted, fetch_fault, id_valid, m_pc, m_halt, e_fault, e_valid);
         end
         if (e_valid) begin
            n_checks++; if (id_pc !== e_pc) begin n_errors++; $display("FAIL rand[%0d] id_pc got=%h exp=%h", c, id_pc, e_pc); end
         end
         if (!e_instr_x) begin
            n_checks++; if (id_instr !== e_instr) begin n_errors++; $display("FAIL rand[%0d] id_instr got=%h exp=%h", c, id_instr, e_instr); end
         end
      end
      stall = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
   endtask

   initial begin
      fill_mem();
      test_reset();
      test_boot();
      test_stall();
      test_redirect_stall();
      test_misaligned();
      test_out_of_range();
      test_halt_vs_redirect();
      test_reset_midflight();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: IMEM_BYTES, 32, size in bytes of the instruction memory that is addressed.
REQ-003 Parameter: NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: imem_pc  out  32  byte address to instruction memory, equal to the PC register (combinational).
REQ-007 Port: imem_instr  in  32  instruction returned combinationally by instruction memory for imem_pc.
REQ-008 Port: stall  in  1  hold PC and IF/ID outputs.
REQ-009 Port: redirect_valid  in  1  taken branch/jump from execute.
REQ-010 Port: redirect_pc  in  32  target address accompanying redirect_valid.
REQ-011 Port: halt_req  in  1  stop fetching.
REQ-012 Port: id_valid  out  1  IF/ID register holds a real instruction.
REQ-013 Port: id_pc  out  32  PC of id_instr.
REQ-014 Port: id_instr  out  32  fetched instruction (IF/ID register).
REQ-015 Port: fetch_fault  out  1  sticky error flag: misaligned redirect or out-of-range fetch.
REQ-016 Port: halted  out  1  high while FSM is in HALTED.

Function
REQ-017 FSM states: BOOT, RUN, HALTED; the FSM SHALL enter BOOT on reset.
REQ-018 BOOT SHALL last exactly one cycle with id_valid=0, PC held at RESET_PC, then go to RUN; this gives instruction memory one cycle to initialise.
REQ-019 RUN, stall=0, no redirect, PC in range: id_instr<=imem_instr, id_pc<=PC, id_valid<=1, PC<=PC+4 (mod 2^32); fetch latency is one cycle.
REQ-020 Stall=1 without redirect: PC, id_valid, id_pc, id_instr and state SHALL all hold.
REQ-021 Redirect (any state, overrides stall and halt_req): PC<=redirect_pc with bits [1:0] forced to 0, id_valid<=0, id_instr<=NOP_INSTR, next state RUN.
REQ-022 Redirect with redirect_pc[1:0]!=0 SHALL additionally set fetch_fault.
REQ-023 Out-of-range: in RUN with PC > IMEM_BYTES-4, the block SHALL load id_valid<=0 and id_instr<=NOP_INSTR, set fetch_fault, hold PC and go to HALTED.
REQ-024 halt_req=1 in RUN with stall=0 and no redirect: PC holds, id_valid<=0, next state HALTED; halt_req is ignored while stall=1.
REQ-025 HALTED SHALL keep id_valid=0 and PC frozen; only a redirect or reset SHALL leave HALTED.
REQ-026 fetch_fault SHALL be cleared only by reset.

Reset
REQ-027 Asserted reset SHALL immediately set: PC=RESET_PC, state=BOOT, id_valid=0, id_pc=0, id_instr=NOP_INSTR, fetch_fault=0, halted=0.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight fetch; the first valid fetch after release SHALL come from RESET_PC.

Structure
REQ-029 The FSM state encoding, NOP_INSTR and the default RESET_PC SHALL live in the shared processor package.
REQ-030 The IF/ID pipeline register SHALL be a sub-module, if_id_reg, with load, flush and hold controls.

Verification
REQ-031 Scenario: reset release with imem[0..3]=0xFFC4A303 -> one BOOT cycle with id_valid=0, then id_valid=1, id_pc=0, id_instr=0xFFC4A303; imem_pc=4 the next cycle.
REQ-032 Scenario: stall=1 for 3 cycles at PC=8 -> imem_pc=8 and the id_* outputs are unchanged for 3 cycles; the fetch at 8 completes on the first cycle after stall drops.
REQ-033 Scenario: redirect_valid=1, redirect_pc=0x10, stall=1 at the same time -> next cycle imem_pc=0x10, id_valid=0, id_instr=0x00000013.
REQ-034 Scenario: redirect_pc=0x0E -> imem_pc=0x0C and fetch_fault=1, which stays 1 until reset.
REQ-035 Scenario: sequential fetch up to PC=0x20 with IMEM_BYTES=32 -> fetch_fault=1, halted=1, id_valid=0, PC held at 0x20.
REQ-036 Scenario: halt_req=1 and redirect_valid=1 (redirect_pc=4) in the same cycle -> halted stays 0 and imem_pc=4.
